// File: rtl/router_pkt_reg_if.sv
// router_pkt_reg_if: byte stream, FIFO status, FSM state decodes and
// parity/status returns between the router FSM/source side and the
// packet register stage.
//   master : router FSM / source side (drives bytes and state decodes)
//   slave  : packet register stage (drives dout and status back)
interface router_pkt_reg_if #(
  parameter int DATA_WIDTH = 8
);

  // Source byte stream
  logic                  pkt_valid;
  logic [DATA_WIDTH-1:0] data_in;

  // Destination FIFO status
  logic                  fifo_full;

  // One-hot FSM state decodes
  logic                  detect_add;
  logic                  lfd_state;
  logic                  ld_state;
  logic                  laf_state;
  logic                  full_state;
  logic                  rst_int_reg;

  // Register stage outputs
  logic [DATA_WIDTH-1:0] dout;
  logic                  parity_done;
  logic                  low_packet_valid;
  logic                  err;

  modport master (
    output pkt_valid, data_in, fifo_full,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_packet_valid, err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_packet_valid, err
  );

endinterface : router_pkt_reg_if

// File: rtl/router_pkt_reg.sv
// router_pkt_reg: packet datapath register stage of the 1x3 router.
// Latches the header, steers header/payload/parity bytes onto dout for the
// destination FIFO, parks the byte that arrives while the FIFO is full, and
// reports parity_done / low_packet_valid to the FSM and err to the host.
//
// Optional feature macro: ROUTER_PARITY_CHECK_EN
//   defined   : running parity, received parity byte and err are built.
//   undefined : parity registers are removed and err is tied to 0;
//               parity_done and low_packet_valid behave identically.
//
// All outputs are registered; reset is asynchronous, active-low, and clears
// every register including the data bytes.
module router_pkt_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic              clock,
  input  logic              resetn,
  router_pkt_reg_if.slave   bus
);

  // Local views of the interface inputs
  logic                  pkt_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  fifo_full;
  logic                  detect_add;
  logic                  lfd_state;
  logic                  ld_state;
  logic                  laf_state;
  logic                  rst_int_reg;

  assign pkt_valid   = bus.pkt_valid;
  assign data_in     = bus.data_in;
  assign fifo_full   = bus.fifo_full;
  assign detect_add  = bus.detect_add;
  assign lfd_state   = bus.lfd_state;
  assign ld_state    = bus.ld_state;
  assign laf_state   = bus.laf_state;
  assign rst_int_reg = bus.rst_int_reg;

  // FIFO_FULL_STATE needs no action here: every register simply holds.
  logic unused_full_state;
  assign unused_full_state = bus.full_state;

  // Address field lives in bits [1:0]; address 3 is not a valid port.
  function automatic logic addr_valid(input logic [DATA_WIDTH-1:0] hdr);
    return (hdr[1:0] != 2'b11);
  endfunction

  // Received parity disagrees with the computed running parity.
  function automatic logic parity_mismatch(input logic [DATA_WIDTH-1:0] computed,
                                           input logic [DATA_WIDTH-1:0] received);
    return (computed != received);
  endfunction

  // Byte registers
  logic [DATA_WIDTH-1:0] header_byte_q, header_byte_d;
  logic [DATA_WIDTH-1:0] full_byte_q,   full_byte_d;
  logic [DATA_WIDTH-1:0] dout_q,        dout_d;

  // Status registers
  logic                  parity_done_q,      parity_done_d;
  logic                  low_packet_valid_q, low_packet_valid_d;

  // Decoded events shared by several registers
  logic                  hdr_capture;
  logic                  ld_write;
  logic                  ld_stall;
  logic                  ld_parity_byte;

  assign hdr_capture    = detect_add && pkt_valid && addr_valid(data_in);
  assign ld_write       = ld_state && !fifo_full;
  assign ld_stall       = ld_state && fifo_full;
  assign ld_parity_byte = ld_state && !pkt_valid;

  // Header latch: only valid destination addresses are captured
  always_comb begin
    header_byte_d = header_byte_q;
    if (hdr_capture) begin
      header_byte_d = data_in;
    end
  end

  // Byte parked while the FIFO is full, replayed in LOAD_AFTER_FULL
  always_comb begin
    full_byte_d = full_byte_q;
    if (ld_stall) begin
      full_byte_d = data_in;
    end
  end

  // Output byte mux; decodes are one-hot, dout holds when none applies
  always_comb begin
    dout_d = dout_q;
    if (lfd_state) begin
      dout_d = header_byte_q;
    end else if (ld_write) begin
      dout_d = data_in;
    end else if (laf_state) begin
      dout_d = full_byte_q;
    end
  end

  // parity_done: set once the parity byte reached the FIFO, either directly
  // from LOAD_DATA or via the replay in LOAD_AFTER_FULL
  always_comb begin
    parity_done_d = parity_done_q;
    if (detect_add) begin
      parity_done_d = 1'b0;
    end else if (ld_write && !pkt_valid) begin
      parity_done_d = 1'b1;
    end else if (laf_state && low_packet_valid_q && !parity_done_q) begin
      parity_done_d = 1'b1;
    end
  end

  // low_packet_valid: pkt_valid fell in LOAD_DATA; the FSM's internal reset
  // takes priority so the flag never leaks into the next packet
  always_comb begin
    low_packet_valid_d = low_packet_valid_q;
    if (ld_parity_byte) begin
      low_packet_valid_d = 1'b1;
    end
    if (rst_int_reg) begin
      low_packet_valid_d = 1'b0;
    end
  end

  // Control and data registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      header_byte_q      <= '0;
      full_byte_q        <= '0;
      dout_q             <= '0;
      parity_done_q      <= 1'b0;
      low_packet_valid_q <= 1'b0;
    end else begin
      header_byte_q      <= header_byte_d;
      full_byte_q        <= full_byte_d;
      dout_q             <= dout_d;
      parity_done_q      <= parity_done_d;
      low_packet_valid_q <= low_packet_valid_d;
    end
  end

`ifdef ROUTER_PARITY_CHECK_EN

  logic [DATA_WIDTH-1:0] internal_parity_q, internal_parity_d;
  logic [DATA_WIDTH-1:0] packet_parity_q,   packet_parity_d;
  logic                  err_q,             err_d;

  // Running XOR: header once in LOAD_FIRST_DATA, then every byte sampled in
  // LOAD_DATA with pkt_valid high (stalled bytes are counted on arrival, so
  // the replay in LOAD_AFTER_FULL must not add them again)
  always_comb begin
    internal_parity_d = internal_parity_q;
    if (detect_add) begin
      internal_parity_d = '0;
    end else if (lfd_state) begin
      internal_parity_d = internal_parity_q ^ header_byte_q;
    end else if (ld_state && pkt_valid) begin
      internal_parity_d = internal_parity_q ^ data_in;
    end
  end

  // Received parity byte: the byte present when pkt_valid falls
  always_comb begin
    packet_parity_d = packet_parity_q;
    if (detect_add) begin
      packet_parity_d = '0;
    end else if (ld_parity_byte) begin
      packet_parity_d = data_in;
    end
  end

  // Error flag: evaluated in CHECK_PARITY_ERROR, sticky until the next
  // valid header so the host can read it between packets
  always_comb begin
    err_d = err_q;
    if (rst_int_reg && parity_done_q) begin
      err_d = parity_mismatch(internal_parity_q, packet_parity_q);
    end else if (detect_add && pkt_valid) begin
      err_d = 1'b0;
    end
  end

  // Parity registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      internal_parity_q <= '0;
      packet_parity_q   <= '0;
      err_q             <= 1'b0;
    end else begin
      internal_parity_q <= internal_parity_d;
      packet_parity_q   <= packet_parity_d;
      err_q             <= err_d;
    end
  end

  assign bus.err = err_q;

`else

  // Parity checking not built: the error flag is permanently clear.
  assign bus.err = 1'b0;

`endif

  assign bus.dout             = dout_q;
  assign bus.parity_done      = parity_done_q;
  assign bus.low_packet_valid = low_packet_valid_q;

endmodule : router_pkt_reg

// File: tb/tb_router_pkt_reg.sv
// tb_router_pkt_reg: directed bench for router_pkt_reg. Plays the role of the
// router FSM by driving one-hot state decodes cycle by cycle.
module tb_router_pkt_reg;

  localparam int DW = 8;

  // State decode encodings {detect_add, lfd, ld, laf, full, rst_int_reg}
  localparam logic [5:0] ST_IDLE = 6'b000000;
  localparam logic [5:0] ST_DA   = 6'b100000;
  localparam logic [5:0] ST_LFD  = 6'b010000;
  localparam logic [5:0] ST_LD   = 6'b001000;
  localparam logic [5:0] ST_LAF  = 6'b000100;
  localparam logic [5:0] ST_FFS  = 6'b000010;
  localparam logic [5:0] ST_CPE  = 6'b000001;

`ifdef ROUTER_PARITY_CHECK_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic clock;
  logic resetn;
  int   tests;
  int   fails;
  logic exp_err;

  router_pkt_reg_if #(.DATA_WIDTH(DW)) bus ();

  router_pkt_reg #(.DATA_WIDTH(DW)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive one FSM cycle, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic [5:0] st, input logic pv,
                     input logic [DW-1:0] d, input logic ff);
    {bus.detect_add, bus.lfd_state, bus.ld_state,
     bus.laf_state, bus.full_state, bus.rst_int_reg} = st;
    bus.pkt_valid = pv;
    bus.data_in   = d;
    bus.fifo_full = ff;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cyc_idle_nowait();
    #3;
    tests++; if (bus.dout !== 8'h00) begin fails++; $display("FAIL rst_dout got=%h exp=%h", bus.dout, 8'h00); end
    tests++; if (bus.parity_done !== 1'b0) begin fails++; $display("FAIL rst_pd got=%b exp=0", bus.parity_done); end
    tests++; if (bus.low_packet_valid !== 1'b0) begin fails++; $display("FAIL rst_lpv got=%b exp=0", bus.low_packet_valid); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL rst_err got=%b exp=0", bus.err); end
    #10 resetn = 1'b1;
    cyc(ST_IDLE, 1'b0, 8'h00, 1'b0);
    tests++; if (bus.dout !== 8'h00) begin fails++; $display("FAIL rst_idle_dout got=%h exp=%h", bus.dout, 8'h00); end
  endtask

  task automatic cyc_idle_nowait();
    {bus.detect_add, bus.lfd_state, bus.ld_state,
     bus.laf_state, bus.full_state, bus.rst_int_reg} = ST_IDLE;
    bus.pkt_valid = 1'b0;
    bus.data_in   = '0;
    bus.fifo_full = 1'b0;
  endtask

  task automatic test_good_packet();
    cyc(ST_DA,  1'b1, 8'h09, 1'b0);
    cyc(ST_LFD, 1'b1, 8'h11, 1'b0);
    tests++; if (bus.dout !== 8'h09) begin fails++; $display("FAIL good_hdr dout got=%h exp=%h", bus.dout, 8'h09); end
    cyc(ST_LD,  1'b1, 8'h11, 1'b0);
    tests++; if (bus.dout !== 8'h11) begin fails++; $display("FAIL good_p1 dout got=%h exp=%h", bus.dout, 8'h11); end
    tests++; if (bus.parity_done !== 1'b0) begin fails++; $display("FAIL good_pd_early got=%b exp=0", bus.parity_done); end
    cyc(ST_LD,  1'b1, 8'h22, 1'b0);
    tests++; if (bus.dout !== 8'h22) begin fails++; $display("FAIL good_p2 dout got=%h exp=%h", bus.dout, 8'h22); end
    cyc(ST_LD,  1'b0, 8'h3A, 1'b0);
    tests++; if (bus.dout !== 8'h3A) begin fails++; $display("FAIL good_par dout got=%h exp=%h", bus.dout, 8'h3A); end
    tests++; if (bus.parity_done !== 1'b1) begin fails++; $display("FAIL good_pd got=%b exp=1", bus.parity_done); end
    tests++; if (bus.low_packet_valid !== 1'b1) begin fails++; $display("FAIL good_lpv got=%b exp=1", bus.low_packet_valid); end
    cyc(ST_CPE, 1'b0, 8'h00, 1'b0);
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL good_err got=%b exp=0", bus.err); end
    tests++; if (bus.low_packet_valid !== 1'b0) begin fails++; $display("FAIL good_lpv_clr got=%b exp=0", bus.low_packet_valid); end
    cyc(ST_IDLE, 1'b0, 8'h77, 1'b0);
    tests++; if (bus.dout !== 8'h3A) begin fails++; $display("FAIL good_hold dout got=%h exp=%h", bus.dout, 8'h3A); end
  endtask

  task automatic test_bad_parity();
    exp_err = PAR_EN;
    cyc(ST_DA,  1'b1, 8'h09, 1'b0);
    cyc(ST_LFD, 1'b1, 8'h11, 1'b0);
    cyc(ST_LD,  1'b1, 8'h11, 1'b0);
    cyc(ST_LD,  1'b1, 8'h22, 1'b0);
    cyc(ST_LD,  1'b0, 8'h3B, 1'b0);
    tests++; if (bus.dout !== 8'h3B) begin fails++; $display("FAIL bad_par dout got=%h exp=%h", bus.dout, 8'h3B); end
    cyc(ST_CPE, 1'b0, 8'h00, 1'b0);
    tests++; if (bus.err !== exp_err) begin fails++; $display("FAIL bad_err got=%b exp=%b", bus.err, exp_err); end
    cyc(ST_IDLE, 1'b0, 8'h00, 1'b0);
    cyc(ST_IDLE, 1'b0, 8'h00, 1'b0);
    tests++; if (bus.err !== exp_err) begin fails++; $display("FAIL bad_err_idle got=%b exp=%b", bus.err, exp_err); end
    cyc(ST_DA,  1'b0, 8'h09, 1'b0);
    tests++; if (bus.err !== exp_err) begin fails++; $display("FAIL bad_err_nopv got=%b exp=%b", bus.err, exp_err); end
    cyc(ST_DA,  1'b1, 8'h09, 1'b0);
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL bad_err_clr got=%b exp=0", bus.err); end
    tests++; if (bus.parity_done !== 1'b0) begin fails++; $display("FAIL bad_pd_clr got=%b exp=0", bus.parity_done); end
  endtask

  task automatic test_fifo_full_payload();
    cyc(ST_DA,  1'b1, 8'h09, 1'b0);
    cyc(ST_LFD, 1'b1, 8'h11, 1'b0);
    cyc(ST_LD,  1'b1, 8'h11, 1'b0);
    cyc(ST_LD,  1'b1, 8'h22, 1'b1);
    tests++; if (bus.dout !== 8'h11) begin fails++; $display("FAIL ff_stall dout got=%h exp=%h", bus.dout, 8'h11); end
    cyc(ST_FFS, 1'b1, 8'h22, 1'b1);
    tests++; if (bus.dout !== 8'h11) begin fails++; $display("FAIL ff_full dout got=%h exp=%h", bus.dout, 8'h11); end
    cyc(ST_LAF, 1'b1, 8'h22, 1'b0);
    tests++; if (bus.dout !== 8'h22) begin fails++; $display("FAIL ff_laf dout got=%h exp=%h", bus.dout, 8'h22); end
    tests++; if (bus.parity_done !== 1'b0) begin fails++; $display("FAIL ff_laf_pd got=%b exp=0", bus.parity_done); end
    cyc(ST_LD,  1'b0, 8'h3A, 1'b0);
    tests++; if (bus.dout !== 8'h3A) begin fails++; $display("FAIL ff_par dout got=%h exp=%h", bus.dout, 8'h3A); end
    tests++; if (bus.parity_done !== 1'b1) begin fails++; $display("FAIL ff_pd got=%b exp=1", bus.parity_done); end
    cyc(ST_CPE, 1'b0, 8'h00, 1'b0);
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL ff_err got=%b exp=0", bus.err); end
  endtask

  task automatic test_parity_during_full();
    cyc(ST_DA,  1'b1, 8'h09, 1'b0);
    cyc(ST_LFD, 1'b1, 8'h11, 1'b0);
    cyc(ST_LD,  1'b1, 8'h11, 1'b0);
    cyc(ST_LD,  1'b1, 8'h22, 1'b0);
    cyc(ST_LD,  1'b0, 8'h3A, 1'b1);
    tests++; if (bus.low_packet_valid !== 1'b1) begin fails++; $display("FAIL pf_lpv got=%b exp=1", bus.low_packet_valid); end
    tests++; if (bus.parity_done !== 1'b0) begin fails++; $display("FAIL pf_pd_early got=%b exp=0", bus.parity_done); end
    tests++; if (bus.dout !== 8'h22) begin fails++; $display("FAIL pf_hold dout got=%h exp=%h", bus.dout, 8'h22); end
    cyc(ST_FFS, 1'b0, 8'h3A, 1'b1);
    tests++; if (bus.parity_done !== 1'b0) begin fails++; $display("FAIL pf_ffs_pd got=%b exp=0", bus.parity_done); end
    cyc(ST_LAF, 1'b0, 8'h3A, 1'b0);
    tests++; if (bus.dout !== 8'h3A) begin fails++; $display("FAIL pf_laf dout got=%h exp=%h", bus.dout, 8'h3A); end
    tests++; if (bus.parity_done !== 1'b1) begin fails++; $display("FAIL pf_pd got=%b exp=1", bus.parity_done); end
    cyc(ST_CPE, 1'b0, 8'h00, 1'b0);
    tests++; if (bus.low_packet_valid !== 1'b0) begin fails++; $display("FAIL pf_lpv_clr got=%b exp=0", bus.low_packet_valid); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL pf_err got=%b exp=0", bus.err); end
    tests++; if (bus.parity_done !== 1'b1) begin fails++; $display("FAIL pf_pd_hold got=%b exp=1", bus.parity_done); end
  endtask

  task automatic test_addr3();
    // Header register still holds 8'h09 from the previous packet.
    cyc(ST_DA,  1'b1, 8'h0F, 1'b0);
    tests++; if (bus.dout !== 8'h3A) begin fails++; $display("FAIL a3_dout got=%h exp=%h", bus.dout, 8'h3A); end
    cyc(ST_LFD, 1'b1, 8'h55, 1'b0);
    tests++; if (bus.dout !== 8'h09) begin fails++; $display("FAIL a3_hdr dout got=%h exp=%h", bus.dout, 8'h09); end
  endtask

  task automatic test_reset_midpacket();
    cyc(ST_LD, 1'b0, 8'hA5, 1'b0);
    tests++; if (bus.dout !== 8'hA5) begin fails++; $display("FAIL mr_pre dout got=%h exp=%h", bus.dout, 8'hA5); end
    tests++; if (bus.low_packet_valid !== 1'b1) begin fails++; $display("FAIL mr_pre_lpv got=%b exp=1", bus.low_packet_valid); end
    #2 resetn = 1'b0;
    #1;
    tests++; if (bus.dout !== 8'h00) begin fails++; $display("FAIL mr_dout got=%h exp=%h", bus.dout, 8'h00); end
    tests++; if (bus.parity_done !== 1'b0) begin fails++; $display("FAIL mr_pd got=%b exp=0", bus.parity_done); end
    tests++; if (bus.low_packet_valid !== 1'b0) begin fails++; $display("FAIL mr_lpv got=%b exp=0", bus.low_packet_valid); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL mr_err got=%b exp=0", bus.err); end
    #3 resetn = 1'b1;
    cyc(ST_LFD, 1'b1, 8'h44, 1'b0);
    tests++; if (bus.dout !== 8'h00) begin fails++; $display("FAIL mr_hdr_clr dout got=%h exp=%h", bus.dout, 8'h00); end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    exp_err = 1'b0;
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_fifo_full_payload();
    test_parity_during_full();
    test_addr3();
    test_reset_midpacket();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_router_pkt_reg

// File: doc/router_pkt_reg.md
# router_pkt_reg

Packet datapath register stage for the 1x3 router. It sits directly downstream of the router FSM and consumes its state decodes (`detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `rst_int_reg`). It latches the header, steers header, payload and parity bytes onto `dout` for the destination FIFO, and holds the byte that arrived while the FIFO was full. It also accumulates running parity and returns `parity_done` and `low_packet_valid` to the FSM, plus `err` to the host.

## Interface
- `DATA_WIDTH`, 8, width of `data_in`, `dout` and all internal byte registers; minimum 2, since bits [1:0] carry the address.
- `clock` input 1: single clock; all logic is on its rising edge.
- `resetn` input 1: reset is asynchronous and active-low. Named as in the codebase.
- `pkt_valid` input 1: source byte valid; a falling edge marks the parity byte.
- `data_in` input DATA_WIDTH: source byte (header, payload or parity).
- `fifo_full` input 1: selected destination FIFO is full.
- `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `rst_int_reg` input 1 each: one-hot FSM state decodes.
- `dout` output DATA_WIDTH: byte presented to the FIFO write port.
- `parity_done` output 1: parity byte has been captured for the current packet.
- `low_packet_valid` output 1: `pkt_valid` fell while in LOAD_DATA.
- `err` output 1: received parity does not match the computed parity.

## Operation
- Internal registers:
  - `header_byte` holds the latched header.
  - `full_byte` holds the byte that arrived while the FIFO was full.
  - `internal_parity` is the running XOR.
  - `packet_parity` is the received parity byte.
- Header capture: when `detect_add && pkt_valid && data_in[1:0]!=2'b11`, set `header_byte<=data_in`. Address 3 is ignored.
- `dout` mux. The state decodes are mutually exclusive; `dout` holds when none applies.
  - `lfd_state`: `dout<=header_byte`.
  - `ld_state && !fifo_full`: `dout<=data_in`. This includes the parity byte.
  - `ld_state && fifo_full`: `full_byte<=data_in`; `dout` holds.
  - `laf_state`: `dout<=full_byte`.
- Parity accumulation:
  - On `detect_add`, clear `internal_parity`.
  - On `lfd_state`, XOR in `header_byte`.
  - On `ld_state && pkt_valid`, XOR in `data_in`, regardless of `fifo_full`, so each payload byte counts exactly once.
- Packet parity: on `ld_state && !pkt_valid`, set `packet_parity<=data_in`. `packet_parity` is cleared on `detect_add`.
- `parity_done`:
  - Cleared on `detect_add`.
  - Set on `ld_state && !fifo_full && !pkt_valid`.
  - Set on `laf_state && low_packet_valid && !parity_done`.
  - Otherwise holds.
- `low_packet_valid`:
  - Set on `ld_state && !pkt_valid`.
  - Cleared on `rst_int_reg`. Clear wins if both occur.
- `err`:
  - When `rst_int_reg && parity_done`, set `err<=(internal_parity!=packet_parity)`.
  - Cleared on `detect_add && pkt_valid`.
  - Otherwise holds through idle.

## Timing
- Reset (`resetn`=0, asynchronous): `dout`=0, `err`=0, `parity_done`=0, `low_packet_valid`=0, and all internal registers 0. No clock is needed.
- Latency: every output is registered, one cycle after the qualifying state decode. The header appears on `dout` the cycle after LOAD_FIRST_DATA.
- `parity_done` is visible to the FSM in the cycle following LOAD_DATA. This lets LOAD_AFTER_FULL choose DECODE_ADDRESS.
- Parity byte arriving with `fifo_full`=1: the byte goes to `full_byte` and is recorded in `packet_parity`. `low_packet_valid` sets. `parity_done` sets later, in `laf_state`.
- Back-to-back packets: `detect_add` in the cycle after CHECK_PARITY_ERROR clears parity state. `err` from the previous packet persists until the next valid header.
- FSM soft reset mid-packet: no special handling. The next `detect_add` re-initialises all per-packet state.

## Configuration
- `ROUTER_PARITY_CHECK_EN` defined: parity accumulation, `packet_parity` and `err` are implemented as described.
- `ROUTER_PARITY_CHECK_EN` undefined:
  - `internal_parity` and `packet_parity` are removed.
  - `err` is tied to 0.
  - `parity_done` and `low_packet_valid` behave unchanged.

## Test plan
- Reset mid-packet with `ld_state`=1 and `dout`=8'hA5: assert `resetn`=0 between clock edges. All outputs read 0 immediately, before the next edge.
- Good packet to port 1:
  - Stimulus: header 8'h09, payload 8'h11, 8'h22, parity 8'h3A (the XOR of the three).
  - `dout` sequence: 09, 11, 22, 3A.
  - `parity_done`=1 the cycle after the parity byte; `err`=0 after CHECK_PARITY_ERROR.
- Corrupt parity: same packet with parity 8'h3B. `err`=1 after `rst_int_reg`; `err` stays 1 until the next header with `pkt_valid`.
- FIFO full on the 2nd payload byte 8'h22:
  - `dout` holds 8'h11 through FIFO_FULL_STATE.
  - `dout`=8'h22 in the cycle after `laf_state`.
  - Final `err`=0.
- Parity byte during full:
  - `fifo_full`=1 when `pkt_valid` falls with 8'h3A.
  - `low_packet_valid`=1 next cycle; `parity_done` rises after `laf_state`.
  - `low_packet_valid` clears after `rst_int_reg`.
- Address 3 header 8'h0F with `detect_add`=1: `header_byte` unchanged and no output change.
